dist_argmin_ctrl: RTL and testbench

DIST_ARGMIN_CTRL -- requirements
Module: dist_argmin_ctrl

---
 rtl/dist_argmin_ctrl.sv | 146 ++++++++++++++
 tb/tb_dist_argmin_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/dist_argmin_ctrl.sv
// dist_argmin_ctrl
//
// Streams NUM_CLS unsigned class distances, one beat per cycle, and reports
// the smallest distance together with the index of the class that produced it.
// Ties keep the earlier (lower) class index.
//
// Build option:
//   DIST_ARGMIN_MARGIN_EN - when defined, adds out_margin = second-smallest
//                           minus smallest distance (0 when NUM_CLS == 1).
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   begin a query (sampled only when idle)
//   clear      in   synchronous abort back to idle, beats start
//   in_valid   in   distance beat valid
//   in_ready   out  high while accumulating; beat taken on in_valid && in_ready
//   in_dist    in   class distance [DW]
//   out_valid  out  result valid
//   out_ready  in   result consumed on out_valid && out_ready
//   out_dist   out  minimum distance [DW]
//   out_cls    out  class index of the minimum [CLSW]
//   busy       out  high while accumulating or holding a result
//   out_margin out  (option only) second-smallest minus smallest [DW]
module dist_argmin_ctrl #(
    parameter int DW      = 32,
    parameter int CLSW    = 16,
    parameter int NUM_CLS = 10
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clear,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_dist,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_dist,
    output logic [CLSW-1:0] out_cls,
    output logic            busy
`ifdef DIST_ARGMIN_MARGIN_EN
    ,
    output logic [DW-1:0]   out_margin
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Index of the final beat of a query; the counter stops here, so it never wraps.
    localparam logic [CLSW-1:0] LAST_IDX = CLSW'(NUM_CLS - 1);

    state_t            state_reg;
    logic [CLSW-1:0]   cnt_reg;
    logic [DW-1:0]     best_dist_reg;
    logic [CLSW-1:0]   best_cls_reg;

    logic beat;
    assign beat = (state_reg == ACCUM) && in_valid;

`ifdef DIST_ARGMIN_MARGIN_EN
    logic [DW-1:0] second_dist_reg;
    logic          second_vld_reg;   // a second distance has been seen this query
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            best_dist_reg   <= '0;
            best_cls_reg    <= '0;
`ifdef DIST_ARGMIN_MARGIN_EN
            second_dist_reg <= '0;
            second_vld_reg  <= 1'b0;
`endif
        end else if (clear) begin
            // Abort wins over everything, including a simultaneous start.
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            best_dist_reg   <= '0;
            best_cls_reg    <= '0;
`ifdef DIST_ARGMIN_MARGIN_EN
            second_dist_reg <= '0;
            second_vld_reg  <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg <= ACCUM;
                        cnt_reg   <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        // First beat loads unconditionally; later beats need a
                        // strictly smaller distance so ties keep the older index.
                        if (cnt_reg == '0 || in_dist < best_dist_reg) begin
                            best_dist_reg <= in_dist;
                            best_cls_reg  <= cnt_reg;
                        end
`ifdef DIST_ARGMIN_MARGIN_EN
                        if (cnt_reg == '0) begin
                            second_vld_reg <= 1'b0;
                        end else if (in_dist < best_dist_reg) begin
                            // Old best is demoted to runner-up.
                            second_dist_reg <= best_dist_reg;
                            second_vld_reg  <= 1'b1;
                        end else if (!second_vld_reg || in_dist < second_dist_reg) begin
                            second_dist_reg <= in_dist;
                            second_vld_reg  <= 1'b1;
                        end
`endif
                        if (cnt_reg == LAST_IDX) begin
                            state_reg <= DONE;
                        end else begin
                            cnt_reg <= cnt_reg + CLSW'(1);
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Handshake outputs are pure decodes of the state register.
    assign in_ready  = (state_reg == ACCUM);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == ACCUM) || (state_reg == DONE);
    assign out_dist  = best_dist_reg;
    assign out_cls   = best_cls_reg;

`ifdef DIST_ARGMIN_MARGIN_EN
    assign out_margin = second_vld_reg ? (second_dist_reg - best_dist_reg) : '0;
`endif

endmodule

// File: tb/tb_dist_argmin_ctrl.sv
module tb_dist_argmin_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, clear, in_valid, out_ready;
    logic        in_ready, out_valid, busy;
    logic [31:0] in_dist, out_dist;
    logic [15:0] out_cls;

    // Second instance with a single class per query.
    logic        start1, in_valid1, out_ready1;
    logic        in_ready1, out_valid1, busy1;
    logic [31:0] in_dist1, out_dist1;
    logic [15:0] out_cls1;

`ifdef DIST_ARGMIN_MARGIN_EN
    logic [31:0] out_margin, out_margin1;
`endif

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    dist_argmin_ctrl #(.DW(32), .CLSW(16), .NUM_CLS(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_dist(in_dist),
        .out_valid(out_valid), .out_ready(out_ready), .out_dist(out_dist),
        .out_cls(out_cls), .busy(busy)
`ifdef DIST_ARGMIN_MARGIN_EN
        , .out_margin(out_margin)
`endif
    );

    dist_argmin_ctrl #(.DW(32), .CLSW(16), .NUM_CLS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .clear(clear),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_dist(in_dist1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_dist(out_dist1),
        .out_cls(out_cls1), .busy(busy1)
`ifdef DIST_ARGMIN_MARGIN_EN
        , .out_margin(out_margin1)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded wait).
    task automatic beat(input logic [31:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_dist  = d;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (!in_ready) check("beat_timeout", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [31:0] d, input logic [15:0] c);
        check({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_dist"},  {32'd0, out_dist}, {32'd0, d});
        check({tag, "_cls"},   {48'd0, out_cls},  {48'd0, c});
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] vals [4];
        rst_n = 1'b0; start = 1'b0; clear = 1'b0; in_valid = 1'b0;
        in_dist = '0; out_ready = 1'b0;
        start1 = 1'b0; in_valid1 = 1'b0; in_dist1 = '0; out_ready1 = 1'b0;

        // Reset state, before any clock edge.
        #1;
        check("rst_busy",      {63'd0, busy},      64'd0);
        check("rst_in_ready",  {63'd0, in_ready},  64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_dist",  {32'd0, out_dist},  64'd0);
        check("rst_out_cls",   {48'd0, out_cls},   64'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Query 1: 50,20,70,30 back-to-back.
        do_start();
        check("q1_in_ready", {63'd0, in_ready}, 64'd1);
        beat(50); beat(20); beat(70);
        check("q1_not_done_early", {63'd0, out_valid}, 64'd0);
        beat(30);
        check_result("q1", 32'd20, 16'd1);
        check("q1_in_ready_done", {63'd0, in_ready}, 64'd0);
`ifdef DIST_ARGMIN_MARGIN_EN
        check("q1_margin", {32'd0, out_margin}, 64'd10);
`endif
        consume();
        check("q1_idle_busy", {63'd0, busy},      64'd0);
        check("q1_idle_valid", {63'd0, out_valid}, 64'd0);

        // in_valid in IDLE must be ignored (a 0 here would beat every real value).
        in_valid = 1'b1; in_dist = 32'd0;
        tick();
        check("idle_in_ready", {63'd0, in_ready}, 64'd0);
        check("idle_busy",     {63'd0, busy},     64'd0);
        in_valid = 1'b0;

        // Query 2: ties keep the earlier index.
        do_start();
        beat(9); beat(5); beat(5); beat(8);
        check_result("q2", 32'd5, 16'd1);
`ifdef DIST_ARGMIN_MARGIN_EN
        check("q2_margin", {32'd0, out_margin}, 64'd0);
`endif
        consume();

        // Query 3: random gaps, then back-pressure with start asserted.
        vals = '{32'd7, 32'd3, 32'd3, 32'd1};
        do_start();
        foreach (vals[i]) begin
            repeat ($urandom_range(0, 3)) tick();
            beat(vals[i]);
        end
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_result($sformatf("q3_hold%0d", k), 32'd1, 16'd3);
            tick();
        end
        start = 1'b0;
        consume();
        check("q3_idle_busy", {63'd0, busy}, 64'd0);
        tick();
        check("q3_stays_idle", {63'd0, busy}, 64'd0);

        // clear together with start: clear wins.
        start = 1'b1; clear = 1'b1;
        tick();
        start = 1'b0; clear = 1'b0;
        check("clr_start_busy", {63'd0, busy}, 64'd0);

        // Query 4: abort after two small beats, then a clean query.
        do_start();
        beat(1); beat(1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("q4_clear_busy", {63'd0, busy}, 64'd0);
        do_start();
        beat(4); beat(4); beat(4); beat(4);
        check_result("q4", 32'd4, 16'd0);
        consume();

        // Query 5: asynchronous reset mid-query.
        do_start();
        beat(1); beat(2); beat(3);
        rst_n = 1'b0;
        #1;
        check("ar_busy",     {63'd0, busy},      64'd0);
        check("ar_in_ready", {63'd0, in_ready},  64'd0);
        check("ar_valid",    {63'd0, out_valid}, 64'd0);
        check("ar_dist",     {32'd0, out_dist},  64'd0);
        check("ar_cls",      {48'd0, out_cls},   64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        do_start();
        repeat (4) beat(32'hFFFF_FFFF);
        check_result("q5", 32'hFFFF_FFFF, 16'd0);
        consume();

        // Single-class instance: first beat goes straight to DONE.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check("n1_in_ready", {63'd0, in_ready1}, 64'd1);
        in_valid1 = 1'b1; in_dist1 = 32'd42;
        tick();
        in_valid1 = 1'b0;
        check("n1_valid", {63'd0, out_valid1}, 64'd1);
        check("n1_dist",  {32'd0, out_dist1},  64'd42);
        check("n1_cls",   {48'd0, out_cls1},   64'd0);
`ifdef DIST_ARGMIN_MARGIN_EN
        check("n1_margin", {32'd0, out_margin1}, 64'd0);
`endif
        out_ready1 = 1'b1;
        tick();
        out_ready1 = 1'b0;
        check("n1_idle", {63'd0, busy1}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
